dino_jump_ctrl: RTL and testbench
=================================

DINO_JUMP_CTRL -- requirements
Module: dino_jump_ctrl

Interface
REQ-001 SHALL have parameter GROUND_Y, default 9'd146, meaning the dinosaur's top-left Y coordinate when it stands on the ground.
REQ-002 SHALL have parameter KEY_CODE, default 8'h12, meaning the PS/2 make code that triggers a jump.
REQ-003 SHALL have parameter PAD_CODE, default 5'h10, meaning the keypad code that triggers a jump.
REQ-004 Ports SHALL be:
- clk  in  1  single system clock; all logic on its rising edge.
- clrn  in  1  synchronous, active-low reset.
- tick  in  1  one-clk physics step enable, from the clock divider.
- ps2_ready  in  1  level; high while ps2_data is valid.
- ps2_data  in  10  [7:0] scan code, [8] break flag, [9] extended flag.
- pad_ready  in  1  level; high while pad_code is valid.
- pad_code  in  5  keypad key code.
- dino_y  out  9  current top-left Y coordinate.
- airborne  out  1  high while a jump is in progress.
- jump_start  out  1  one-clk pulse when a jump is accepted.
- step  out  6  current jump step index, 0..63.

Function
REQ-005 SHALL register ps2_ready and pad_ready each cycle and detect rising edges only; a level held high SHALL produce one event.
REQ-006 A PS/2 event SHALL be valid only when all of these hold: ps2_data[7:0]==KEY_CODE, ps2_data[8]==0, ps2_data[9]==0.
REQ-007 A pad event SHALL be valid only when pad_code==PAD_CODE.
REQ-008 A jump request SHALL be the OR of a valid PS/2 event and a valid pad event; simultaneous events SHALL count as one request.
REQ-009 The FSM SHALL have exactly three states: GROUND, RISE, FALL.
REQ-010 In GROUND, a request SHALL cause all of the following on the next edge:
- move to RISE;
- set step to 0;
- set airborne to 1;
- pulse jump_start high for one cycle.
REQ-011 In GROUND, dino_y SHALL hold GROUND_Y, and tick SHALL have no effect.
REQ-012 In RISE or FALL, requests SHALL be ignored: no jump_start and no restart.
REQ-013 In RISE or FALL, dino_y and step SHALL change only on a clk edge where tick==1.
REQ-014 On a tick, dino_y SHALL update by a delta selected by step:
- steps 0-9: -6
- steps 10-19: -4
- steps 20-31: -2
- steps 32-43: +2
- steps 44-53: +4
- steps 54-63: +6
REQ-015 The apex SHALL be GROUND_Y-124; the net displacement over 64 steps SHALL be 0.
REQ-016 On each tick, step SHALL increment by 1.
REQ-017 The transition RISE->FALL SHALL occur on the tick that applies step 31.
REQ-018 On the tick that applies step 63, the block SHALL do all of the following:
- move to GROUND;
- set airborne to 0;
- set step to 0;
- force dino_y to exactly GROUND_Y, regardless of arithmetic.
REQ-019 A request and a tick in the same GROUND cycle SHALL only start the jump; the first displacement SHALL occur on the next tick.
REQ-020 A request on the same edge that lands the dinosaur (step 63 tick) SHALL be ignored.
REQ-021 All outputs SHALL be registered; dino_y SHALL reflect a tick one clk after the tick edge.
REQ-022 Arithmetic SHALL be 9-bit unsigned; GROUND_Y SHALL be >=124 and <=447, so no wrap-around occurs.
REQ-023 A jump lasts 64 ticks; no jump_start SHALL occur within 64 ticks of the previous one.

Reset
REQ-024 On a clk edge with clrn==0, the block SHALL set:
- state GROUND;
- dino_y=GROUND_Y;
- airborne=0;
- jump_start=0;
- step=0;
- both ready-history registers to 1.
REQ-025 Because history resets to 1, a ready line held high across reset release SHALL NOT trigger a jump.
REQ-026 Reset asserted mid-jump SHALL return dino_y to GROUND_Y on that edge, with no further motion.

Verification
REQ-027 Bench SHALL cover basic jump: pad_ready rises with pad_code=5'h10, then 64 ticks -> jump_start one pulse; dino_y reaches 146-60=86 at step 10, 46 at step 20, 22 (apex) after step 31, then 146 after step 63; airborne low after that.
REQ-028 Bench SHALL cover filtering: ps2_data=10'h112 (break) and ps2_data=10'h059 -> no jump; ps2_data=10'h012 -> jump starts.
REQ-029 Bench SHALL cover re-trigger: a second valid event at step 20 -> ignored, trajectory unchanged; a new event after landing -> new jump.
REQ-030 Bench SHALL cover held/simultaneous input: ps2_ready held high for 200 clk, with pad and PS/2 edges in the same cycle -> exactly one jump_start.
REQ-031 Bench SHALL cover mid-jump reset: clrn low at step 40 -> next edge dino_y=146, airborne=0, step=0; ready held high through reset release -> no jump.
REQ-032 Bench SHALL cover same-cycle request+tick: request and tick in the same GROUND cycle -> dino_y stays 146 until the next tick, then 140.

Source files
------------

// File: rtl/dino_jump_ctrl_if.sv
// Dinosaur jump controller bus: input-event signals and registered motion outputs.
//   master : drives tick, ps2_ready/ps2_data, pad_ready/pad_code; observes outputs
//   slave  : the controller; receives inputs, drives dino_y, airborne, jump_start, step
interface dino_jump_ctrl_if;
   logic       tick;
   logic       ps2_ready;
   logic [9:0] ps2_data;
   logic       pad_ready;
   logic [4:0] pad_code;
   logic [8:0] dino_y;
   logic       airborne;
   logic       jump_start;
   logic [5:0] step;

   modport master (
      output tick, ps2_ready, ps2_data, pad_ready, pad_code,
      input  dino_y, airborne, jump_start, step
   );

   modport slave (
      input  tick, ps2_ready, ps2_data, pad_ready, pad_code,
      output dino_y, airborne, jump_start, step
   );
endinterface

// File: rtl/dino_jump_ctrl.sv
// Dinosaur jump controller. Turns a PS/2 key or keypad press into a 64-tick
// jump trajectory and reports the current Y coordinate.
// Ports:
//   clk   - system clock, rising edge
//   clrn  - synchronous active-low reset
//   bus   - dino_jump_ctrl_if.slave: tick, ps2_ready/ps2_data, pad_ready/pad_code
//           in; dino_y, airborne, jump_start, step out (all registered)
//
// state  | meaning
// GROUND | standing at GROUND_Y, waiting for a jump request
// RISE   | ascending, steps 0..31
// FALL   | descending, steps 32..63; lands on the step-63 tick
module dino_jump_ctrl #(
   parameter logic [8:0] GROUND_Y = 9'd146,
   parameter logic [7:0] KEY_CODE = 8'h12,
   parameter logic [4:0] PAD_CODE = 5'h10
) (
   input logic            clk,
   input logic            clrn,
   dino_jump_ctrl_if.slave bus
);

   typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;

   state_t     state;
   logic       ps2_q;
   logic       pad_q;
   logic [8:0] y_q;
   logic [5:0] step_q;
   logic       air_q;
   logic       js_q;

   logic       ps2_evt;
   logic       pad_evt;
   logic       req;
   logic [8:0] mag;
   logic [8:0] y_next;

   // Only a make code of the plain (non-extended) jump key counts.
   assign ps2_evt = bus.ps2_ready & ~ps2_q & (bus.ps2_data[7:0] == KEY_CODE) &
                    ~bus.ps2_data[8] & ~bus.ps2_data[9];
   assign pad_evt = bus.pad_ready & ~pad_q & (bus.pad_code == PAD_CODE);
   assign req     = ps2_evt | pad_evt;

   // Symmetric velocity profile: 60+40+24 up, 24+40+60 down, net zero.
   always_comb begin
      mag = 9'd2;
      if (step_q < 6'd10)      mag = 9'd6;
      else if (step_q < 6'd20) mag = 9'd4;
      else if (step_q < 6'd44) mag = 9'd2;
      else if (step_q < 6'd54) mag = 9'd4;
      else                     mag = 9'd6;
      y_next = (step_q < 6'd32) ? (y_q - mag) : (y_q + mag);
   end

   always_ff @(posedge clk) begin
      if (!clrn) begin
         state  <= GROUND;
         y_q    <= GROUND_Y;
         air_q  <= 1'b0;
         js_q   <= 1'b0;
         step_q <= 6'd0;
         // History starts high so a line held across reset release is not an edge.
         ps2_q  <= 1'b1;
         pad_q  <= 1'b1;
      end else begin
         ps2_q <= bus.ps2_ready;
         pad_q <= bus.pad_ready;
         js_q  <= 1'b0;
         case (state)
            GROUND: begin
               y_q    <= GROUND_Y;
               step_q <= 6'd0;
               air_q  <= 1'b0;
               if (req) begin
                  state <= RISE;
                  air_q <= 1'b1;
                  js_q  <= 1'b1;
               end
            end
            RISE: begin
               if (bus.tick) begin
                  y_q    <= y_next;
                  step_q <= step_q + 6'd1;
                  if (step_q == 6'd31) state <= FALL;
               end
            end
            FALL: begin
               if (bus.tick) begin
                  if (step_q == 6'd63) begin
                     // Snap to ground so any arithmetic drift can never accumulate.
                     state  <= GROUND;
                     air_q  <= 1'b0;
                     step_q <= 6'd0;
                     y_q    <= GROUND_Y;
                  end else begin
                     y_q    <= y_next;
                     step_q <= step_q + 6'd1;
                  end
               end
            end
            default: state <= GROUND;
         endcase
      end
   end

   assign bus.dino_y     = y_q;
   assign bus.airborne   = air_q;
   assign bus.jump_start = js_q;
   assign bus.step       = step_q;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Directed bench for dino_jump_ctrl with hand-computed trajectory points.
module tb_dino_jump_ctrl;
   logic clk;
   logic clrn;
   int   n_vec;
   int   n_err;
   int   js_cnt;
   int   js_mark;

   dino_jump_ctrl_if bus ();

   dino_jump_ctrl dut (
      .clk  (clk),
      .clrn (clrn),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (bus.jump_start === 1'b1) js_cnt++;

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   // Each tick is followed by a non-tick cycle so hold behaviour is exercised.
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         bus.tick = 1'b1;
         cyc();
         bus.tick = 1'b0;
         cyc();
      end
   endtask

   task automatic pad_press(input logic [4:0] code);
      bus.pad_code  = code;
      bus.pad_ready = 1'b1;
      cyc();
      bus.pad_ready = 1'b0;
      cyc();
   endtask

   task automatic ps2_press(input logic [9:0] data);
      bus.ps2_data  = data;
      bus.ps2_ready = 1'b1;
      cyc();
      bus.ps2_ready = 1'b0;
      cyc();
   endtask

   task automatic chk_ground(input string tag);
      chk({tag, "_y"}, int'(bus.dino_y), 146);
      chk({tag, "_air"}, int'(bus.airborne), 0);
      chk({tag, "_step"}, int'(bus.step), 0);
   endtask

   initial begin
      n_vec = 0; n_err = 0; js_cnt = 0;
      clrn = 1'b0;
      bus.tick = 1'b0;
      bus.ps2_ready = 1'b0;
      bus.ps2_data = 10'h000;
      bus.pad_ready = 1'b0;
      bus.pad_code = 5'h00;
      idle(3);
      chk_ground("reset");
      chk("reset_js", int'(bus.jump_start), 0);
      clrn = 1'b1;
      idle(2);

      // ground: tick has no effect
      ticks(3);
      chk_ground("gnd_tick");

      // basic jump via keypad
      bus.pad_code  = 5'h10;
      bus.pad_ready = 1'b1;
      cyc();
      chk("basic_js", int'(bus.jump_start), 1);
      chk("basic_air", int'(bus.airborne), 1);
      chk("basic_y0", int'(bus.dino_y), 146);
      bus.pad_ready = 1'b0;
      cyc();
      chk("basic_js_pulse", int'(bus.jump_start), 0);
      ticks(1);
      chk("basic_y1", int'(bus.dino_y), 140);
      ticks(9);
      chk("basic_y10", int'(bus.dino_y), 86);
      chk("basic_s10", int'(bus.step), 10);
      idle(5);
      chk("basic_hold", int'(bus.dino_y), 86);
      ticks(10);
      chk("basic_y20", int'(bus.dino_y), 46);
      ticks(12);
      chk("basic_apex", int'(bus.dino_y), 22);
      chk("basic_s32", int'(bus.step), 32);
      ticks(1);
      chk("basic_y33", int'(bus.dino_y), 24);
      ticks(30);
      chk("basic_y63", int'(bus.dino_y), 140);
      chk("basic_s63", int'(bus.step), 63);
      chk("basic_air63", int'(bus.airborne), 1);
      ticks(1);
      chk_ground("basic_land");
      chk("basic_js_cnt", js_cnt, 1);

      // filtering
      js_mark = js_cnt;
      ps2_press(10'h112);
      chk("filt_break_air", int'(bus.airborne), 0);
      ps2_press(10'h059);
      chk("filt_other_air", int'(bus.airborne), 0);
      ps2_press(10'h212);
      chk("filt_ext_air", int'(bus.airborne), 0);
      pad_press(5'h11);
      chk("filt_pad_air", int'(bus.airborne), 0);
      chk("filt_js_none", js_cnt - js_mark, 0);
      ps2_press(10'h012);
      chk("filt_key_air", int'(bus.airborne), 1);
      chk("filt_js_one", js_cnt - js_mark, 1);
      ticks(64);
      chk_ground("filt_land");

      // re-trigger mid-jump ignored
      js_mark = js_cnt;
      pad_press(5'h10);
      ticks(20);
      chk("retrig_y20", int'(bus.dino_y), 46);
      pad_press(5'h10);
      ps2_press(10'h012);
      chk("retrig_s20", int'(bus.step), 20);
      chk("retrig_js", js_cnt - js_mark, 1);
      ticks(12);
      chk("retrig_apex", int'(bus.dino_y), 22);
      ticks(31);
      chk("retrig_s63", int'(bus.step), 63);
      // request on the landing edge is dropped
      bus.pad_code  = 5'h10;
      bus.pad_ready = 1'b1;
      bus.tick      = 1'b1;
      cyc();
      bus.pad_ready = 1'b0;
      bus.tick      = 1'b0;
      cyc();
      chk_ground("retrig_land");
      chk("retrig_land_js", js_cnt - js_mark, 1);
      pad_press(5'h10);
      chk("retrig_new_air", int'(bus.airborne), 1);
      chk("retrig_new_js", js_cnt - js_mark, 2);
      ticks(64);
      chk_ground("retrig_new_land");

      // held + simultaneous input
      js_mark = js_cnt;
      bus.ps2_data  = 10'h012;
      bus.ps2_ready = 1'b1;
      bus.pad_code  = 5'h10;
      bus.pad_ready = 1'b1;
      cyc();
      bus.pad_ready = 1'b0;
      idle(199);
      chk("held_js", js_cnt - js_mark, 1);
      ticks(64);
      chk_ground("held_land");
      idle(5);
      chk("held_after_air", int'(bus.airborne), 0);
      bus.ps2_ready = 1'b0;
      cyc();

      // mid-jump reset with ready held through release
      js_mark = js_cnt;
      pad_press(5'h10);
      ticks(40);
      chk("rst_s40", int'(bus.step), 40);
      chk("rst_y40", int'(bus.dino_y), 38);
      bus.ps2_data  = 10'h012;
      bus.ps2_ready = 1'b1;
      bus.pad_code  = 5'h10;
      bus.pad_ready = 1'b1;
      clrn = 1'b0;
      cyc();
      chk_ground("rst_edge");
      cyc();
      clrn = 1'b1;
      idle(3);
      ticks(3);
      chk_ground("rst_release");
      chk("rst_js", js_cnt - js_mark, 1);
      bus.ps2_ready = 1'b0;
      bus.pad_ready = 1'b0;
      cyc();

      // request and tick in the same ground cycle
      bus.pad_code  = 5'h10;
      bus.pad_ready = 1'b1;
      bus.tick      = 1'b1;
      cyc();
      bus.pad_ready = 1'b0;
      bus.tick      = 1'b0;
      chk("same_y", int'(bus.dino_y), 146);
      chk("same_air", int'(bus.airborne), 1);
      chk("same_step", int'(bus.step), 0);
      idle(4);
      chk("same_hold", int'(bus.dino_y), 146);
      ticks(1);
      chk("same_y1", int'(bus.dino_y), 140);
      chk("same_s1", int'(bus.step), 1);
      ticks(63);
      chk_ground("same_land");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
